// File: rtl/ddr_sample_fetch_if.sv
// ddr_sample_fetch_if: bundles the wave-player byte port and the MiSTer
// DDRAM port of ddr_sample_fetch.
//   player : I_RD, I_RD_ADDR, I_FLUSH -> O_RD_DATA, O_RD_READY, O_BUSY
//   DDRAM  : DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY -> DDRAM_RD,
//            DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_WE
// slave  = the fetch block, master = the environment (player + DDR).
interface ddr_sample_fetch_if;
  logic        I_RD;
  logic [27:0] I_RD_ADDR;
  logic        I_FLUSH;
  logic [7:0]  O_RD_DATA;
  logic        O_RD_READY;
  logic        O_BUSY;
  logic        DDRAM_BUSY;
  logic        DDRAM_RD;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_WE;

  modport slave (
    input  I_RD, I_RD_ADDR, I_FLUSH, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output O_RD_DATA, O_RD_READY, O_BUSY, DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT,
           DDRAM_WE
  );
  modport master (
    output I_RD, I_RD_ADDR, I_FLUSH, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  O_RD_DATA, O_RD_READY, O_BUSY, DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT,
           DDRAM_WE
  );
endinterface

// File: rtl/ddr_sample_fetch.sv
// ddr_sample_fetch: byte-read front end between the DDRAM port and the wave
// sample player. Two resident 8-byte lines; the line after the most recently
// used one is prefetched so a sequential stream crosses lines without a stall.
// Ports:
//   I_CLK   system clock
//   I_RSTn  asynchronous active-low reset
//   bus     ddr_sample_fetch_if.slave (player byte port + DDRAM read port)
// Parameter BASE_WORD: DDRAM word address of byte 0.
module ddr_sample_fetch #(
  parameter logic [28:0] BASE_WORD = 29'h06000000
) (
  input  logic               I_CLK,
  input  logic               I_RSTn,
  ddr_sample_fetch_if.slave  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DREQ  = 3'd1;
  localparam logic [2:0] DWAIT = 3'd2;
  localparam logic [2:0] PREQ  = 3'd3;
  localparam logic [2:0] PWAIT = 3'd4;

  logic [2:0]       state;
  logic [1:0]       vld;
  logic [1:0][24:0] tag;
  logic [1:0][63:0] data;
  logic             mru;
  logic             req_slot;
  logic [24:0]      req_tag;
  logic [28:0]      req_word;
  logic             flushed;   // flush seen while a read was outstanding
  logic             dvalid;
  logic [7:0]       rd_data;
  logic [27:0]      rd_addr_q;

  logic [24:0] cur_tag, nxt_tag;
  logic [2:0]  off;
  logic [1:0]  hit_vec;
  logic        hit, hit_slot, nxt_res, pf_need, fill, byp;

  function automatic logic [7:0] sel_byte(input logic [63:0] w, input logic [2:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  always_comb begin
    cur_tag    = bus.I_RD_ADDR[27:3];
    off        = bus.I_RD_ADDR[2:0];
    hit_vec[0] = vld[0] && (tag[0] == cur_tag);
    hit_vec[1] = vld[1] && (tag[1] == cur_tag);
    hit        = bus.I_RD && (|hit_vec);
    hit_slot   = hit_vec[1];
    nxt_tag    = tag[mru] + 25'd1;
    nxt_res    = (vld[0] && (tag[0] == nxt_tag)) || (vld[1] && (tag[1] == nxt_tag));
    // Only prefetch behind a real line; avoids a spurious fetch after reset/flush.
    pf_need    = vld[mru] && !nxt_res;
    fill       = bus.DDRAM_DOUT_READY && ((state == DWAIT) || (state == PWAIT));
    // Demand fill forwards the byte straight from the bus unless a flush
    // invalidated the data in flight.
    byp        = fill && (state == DWAIT) && bus.I_RD && (cur_tag == req_tag) &&
                 !flushed && !bus.I_FLUSH;
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state     <= IDLE;
      vld       <= '0;
      tag       <= '0;
      data      <= '0;
      mru       <= 1'b0;
      req_slot  <= 1'b0;
      req_tag   <= '0;
      req_word  <= BASE_WORD;
      flushed   <= 1'b0;
      dvalid    <= 1'b0;
      rd_data   <= '0;
      rd_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.I_FLUSH) begin
            if (bus.I_RD && !hit) begin
              state     <= DREQ;
              req_slot  <= ~mru;
              vld[~mru] <= 1'b0;
              req_tag   <= cur_tag;
              req_word  <= BASE_WORD + {4'b0, cur_tag};
              flushed   <= 1'b0;
            end else if (pf_need) begin
              // Target keeps its old line valid until the fill overwrites it.
              state    <= PREQ;
              req_slot <= ~mru;
              req_tag  <= nxt_tag;
              req_word <= BASE_WORD + {4'b0, nxt_tag};
              flushed  <= 1'b0;
            end
          end
        end
        DREQ:  if (!bus.DDRAM_BUSY) state <= DWAIT;
        PREQ:  if (!bus.DDRAM_BUSY) state <= PWAIT;
        default: begin
          if (fill) begin
            state          <= IDLE;
            tag[req_slot]  <= req_tag;
            data[req_slot] <= bus.DDRAM_DOUT;
            if (!flushed && !bus.I_FLUSH) vld[req_slot] <= 1'b1;
          end
        end
      endcase

      if (bus.I_FLUSH && (state != IDLE)) flushed <= 1'b1;

      if (hit && !bus.I_FLUSH) begin
        rd_data   <= sel_byte(data[hit_slot], off);
        rd_addr_q <= bus.I_RD_ADDR;
        dvalid    <= 1'b1;
        mru       <= hit_slot;
      end else if (byp) begin
        rd_data   <= sel_byte(bus.DDRAM_DOUT, off);
        rd_addr_q <= bus.I_RD_ADDR;
        dvalid    <= 1'b1;
        mru       <= req_slot;
      end

      // Flush overrides every valid update above.
      if (bus.I_FLUSH) begin
        vld    <= '0;
        dvalid <= 1'b0;
      end
    end
  end

  assign bus.O_RD_DATA      = rd_data;
  assign bus.O_RD_READY     = bus.I_RD && dvalid && (rd_addr_q == bus.I_RD_ADDR);
  assign bus.O_BUSY         = (state != IDLE);
  assign bus.DDRAM_RD       = (state == DREQ) || (state == PREQ);
  assign bus.DDRAM_ADDR     = req_word;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_WE       = 1'b0;
endmodule

// File: tb/tb_ddr_sample_fetch.sv
// tb_ddr_sample_fetch: directed bench for ddr_sample_fetch with a small DDR
// responder. Responder data: byte k of line t is (8*t + k + 1) mod 256, so
// line 0 reads back 64'h0807060504030201.
module tb_ddr_sample_fetch;
  localparam logic [28:0] BASE = 29'h06000000;
  localparam int LAT = 6;  // DOUT_READY lands 5 cycles after the accepting edge

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ddr_sample_fetch_if bus();
  ddr_sample_fetch #(.BASE_WORD(BASE)) dut (.I_CLK(clk), .I_RSTn(rstn), .bus(bus));

  int errors = 0, checks = 0;
  int cnt = 0, busy_left = 0, ncmd = 0, nlow = 0;
  logic [28:0] paddr;

  function automatic logic [63:0] mk(input logic [28:0] w);
    logic [28:0] t;
    logic [63:0] r;
    t = w - BASE;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = {t[4:0], 3'b000} + 8'(k) + 8'd1;
    return r;
  endfunction

  // DDR responder: decides at negedge, DUT samples at the next posedge.
  initial begin
    bus.DDRAM_BUSY = 1'b0;
    bus.DDRAM_DOUT = '0;
    bus.DDRAM_DOUT_READY = 1'b0;
    paddr = '0;
    forever begin
      @(negedge clk);
      bus.DDRAM_DOUT_READY = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.DDRAM_DOUT_READY = 1'b1;
          bus.DDRAM_DOUT = mk(paddr);
        end
      end
      bus.DDRAM_BUSY = (busy_left > 0) && bus.DDRAM_RD;
      if (bus.DDRAM_BUSY) busy_left--;
      else if (bus.DDRAM_RD && rstn) begin
        paddr = bus.DDRAM_ADDR;
        cnt = LAT;
        ncmd++;
        if (bus.DDRAM_ADDR - BASE <= 29'd2) nlow++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0, quiet = 0;
    while (quiet < 3 && k < 200) begin
      tick();
      k++;
      if (!bus.O_BUSY && cnt == 0) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", 64'(quiet >= 3), 64'd1);
  endtask

  task automatic wait_ready(output int w);
    tick();
    w = 1;
    while (!bus.O_RD_READY && w < 60) begin
      tick();
      w++;
    end
    chk("ready_timeout", 64'(bus.O_RD_READY), 64'd1);
  endtask

  task automatic flush();
    bus.I_FLUSH = 1'b1;
    tick();
    bus.I_FLUSH = 1'b0;
  endtask

  initial begin
    int w, n0;
    bus.I_RD = 1'b0;
    bus.I_RD_ADDR = '0;
    bus.I_FLUSH = 1'b0;

    // Reset state
    tick();
    chk("rst_ddr_rd", 64'(bus.DDRAM_RD), 64'd0);
    chk("rst_ddr_addr", 64'(bus.DDRAM_ADDR), 64'h06000000);
    chk("rst_data", 64'(bus.O_RD_DATA), 64'd0);
    chk("rst_ready", 64'(bus.O_RD_READY), 64'd0);
    chk("rst_busy", 64'(bus.O_BUSY), 64'd0);
    chk("rst_burstcnt", 64'(bus.DDRAM_BURSTCNT), 64'd1);
    chk("rst_we", 64'(bus.DDRAM_WE), 64'd0);
    rstn = 1'b1;

    // Cold miss at byte 3: ready with 0x04 in cycle 8
    bus.I_RD = 1'b1;
    bus.I_RD_ADDR = 28'h0000003;
    tick();
    chk("cold_rd", 64'(bus.DDRAM_RD), 64'd1);
    chk("cold_addr", 64'(bus.DDRAM_ADDR), 64'h06000000);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk("cold_not_ready", 64'(bus.O_RD_READY), 64'd0);
    end
    tick();
    chk("cold_ready", 64'(bus.O_RD_READY), 64'd1);
    chk("cold_data", 64'(bus.O_RD_DATA), 64'h04);

    // Hit: address change drops ready at once, next cycle ready with new byte
    bus.I_RD_ADDR = 28'h0000005;
    #1;
    chk("addr_change_drop", 64'(bus.O_RD_READY), 64'd0);
    tick();
    chk("hit_ready", 64'(bus.O_RD_READY), 64'd1);
    chk("hit_data", 64'(bus.O_RD_DATA), 64'h06);
    bus.I_RD = 1'b0;
    wait_idle();

    // Sequential stream 0x00..0x17
    flush();
    nlow = 0;
    bus.I_RD = 1'b1;
    for (int a = 0; a < 24; a++) begin
      bus.I_RD_ADDR = 28'(a);
      wait_ready(w);
      chk("seq_data", 64'(bus.O_RD_DATA), 64'(a + 1));
      if (a >= 8) chk("seq_latency", 64'(w), 64'd1);
      repeat (3) tick();
    end
    bus.I_RD = 1'b0;
    wait_idle();
    chk("seq_cmds_lines0_2", 64'(nlow), 64'd3);

    // DDRAM_BUSY held 4 cycles in DREQ
    flush();
    busy_left = 4;
    n0 = ncmd;
    bus.I_RD = 1'b1;
    bus.I_RD_ADDR = 28'h0000020;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("busy_rd_hold", 64'(bus.DDRAM_RD), 64'd1);
      chk("busy_addr_hold", 64'(bus.DDRAM_ADDR), 64'h06000004);
    end
    tick();
    chk("busy_rd_drop", 64'(bus.DDRAM_RD), 64'd0);
    chk("busy_one_cmd", 64'(ncmd - n0), 64'd1);
    wait_ready(w);
    chk("busy_data", 64'(bus.O_RD_DATA), 64'h21);
    bus.I_RD = 1'b0;
    wait_idle();

    // Flush during DWAIT: fill discarded, same address refetched
    flush();
    n0 = ncmd;
    bus.I_RD = 1'b1;
    bus.I_RD_ADDR = 28'h0000040;
    tick();
    tick();
    chk("flush_in_dwait", 64'(bus.O_BUSY), 64'd1);
    flush();
    w = 0;
    while (!bus.DDRAM_RD && w < 40) begin
      chk("flush_not_ready", 64'(bus.O_RD_READY), 64'd0);
      tick();
      w++;
    end
    chk("flush_refetch_rd", 64'(bus.DDRAM_RD), 64'd1);
    wait_ready(w);
    chk("flush_refetch_data", 64'(bus.O_RD_DATA), 64'h41);
    chk("flush_two_cmds", 64'(ncmd - n0), 64'd2);
    bus.I_RD = 1'b0;
    wait_idle();

    // Tag wrap at the top of the byte space
    flush();
    bus.I_RD = 1'b1;
    bus.I_RD_ADDR = 28'hFFFFFF8;
    tick();
    chk("wrap_demand_addr", 64'(bus.DDRAM_ADDR), 64'h07FFFFFF);
    wait_ready(w);
    chk("wrap_data", 64'(bus.O_RD_DATA), 64'hF9);
    w = 0;
    while (!bus.DDRAM_RD && w < 20) begin
      tick();
      w++;
    end
    chk("wrap_pf_rd", 64'(bus.DDRAM_RD), 64'd1);
    chk("wrap_pf_addr", 64'(bus.DDRAM_ADDR), 64'h06000000);
    bus.I_RD = 1'b0;
    tick();
    chk("pwait_busy", 64'(bus.O_BUSY), 64'd1);

    // Reset during PWAIT, stray DOUT_READY after release
    rstn = 1'b0;
    tick();
    chk("mid_rst_rd", 64'(bus.DDRAM_RD), 64'd0);
    chk("mid_rst_addr", 64'(bus.DDRAM_ADDR), 64'h06000000);
    chk("mid_rst_data", 64'(bus.O_RD_DATA), 64'd0);
    chk("mid_rst_busy", 64'(bus.O_BUSY), 64'd0);
    rstn = 1'b1;
    repeat (10) tick();
    chk("stray_busy", 64'(bus.O_BUSY), 64'd0);
    bus.I_RD = 1'b1;
    bus.I_RD_ADDR = 28'h0000000;
    tick();
    chk("stray_no_hit", 64'(bus.O_RD_READY), 64'd0);
    chk("stray_miss_rd", 64'(bus.DDRAM_RD), 64'd1);
    wait_ready(w);
    chk("post_rst_data", 64'(bus.O_RD_DATA), 64'h01);
    bus.I_RD = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
